// File: rtl/hazard_if.sv
// ID-stage request and hazard/forwarding response bundle between control and the hazard scoreboard.
interface hazard_if #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned FWD_SEL_W  = 2
) ();
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic                  id_rs1_used;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwr;
  logic                  id_memrd;
  logic                  kill;
  logic                  stall;
  logic                  issue;
  logic [FWD_SEL_W-1:0]  fwd_a;
  logic [FWD_SEL_W-1:0]  fwd_b;
  logic [15:0]           stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_regwr, id_memrd, kill,
    input  stall, issue, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_regwr, id_memrd, kill,
    output stall, issue, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit that shadows in-flight destinations in a private shift register and
// derives load-use stalls, issue and EX operand forward selects from the ID-stage request.
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W  = 3,
  parameter int unsigned FWD_STAGES  = 3,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned ZERO_REG_EN = 1,
  parameter int unsigned FWD_SEL_W   = 2
) (
  input  logic   clk,
  input  logic   reset,
  hazard_if.slave hz
);

  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwr;
    logic                  memrd;
  } entry_t;

  entry_t               trk_q [FWD_STAGES];
  entry_t               id_entry;
  logic [CNT_W-1:0]     stall_cnt_q;

  logic                 hit_a, hit_b;
  logic                 load_a, load_b;
  logic [FWD_SEL_W-1:0] sel_a, sel_b;
  logic                 raw_stall;
  logic                 stall_c, issue_c;

  // A tracked entry produces source s for the ID instruction
  function automatic logic src_hit(input entry_t e, input logic [REG_ADDR_W-1:0] s,
                                   input logic used, input logic valid);
    return e.v && e.regwr && (e.rd == s) && used && valid &&
           !((ZERO_REG_EN != 0) && (s == '0));
  endfunction

  // Scan oldest to youngest so the youngest producer overwrites any older one
  always_comb begin
    hit_a  = 1'b0;
    hit_b  = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = int'(FWD_STAGES) - 1; k >= 0; k--) begin
      if (src_hit(trk_q[k], hz.id_rs1, hz.id_rs1_used, hz.id_valid)) begin
        hit_a  = 1'b1;
        sel_a  = FWD_SEL_W'(k + 1);
        load_a = trk_q[k].memrd && (k < int'(LOAD_LAT));
      end
      if (src_hit(trk_q[k], hz.id_rs2, hz.id_rs2_used, hz.id_valid)) begin
        hit_b  = 1'b1;
        sel_b  = FWD_SEL_W'(k + 1);
        load_b = trk_q[k].memrd && (k < int'(LOAD_LAT));
      end
    end
  end

  // Kill dominates stall; reset gates every combinational response
  always_comb begin
    raw_stall = (hit_a && load_a) || (hit_b && load_b);
    stall_c   = !reset && !hz.kill && raw_stall;
    issue_c   = !reset && !hz.kill && !raw_stall && hz.id_valid;
    hz.stall  = stall_c;
    hz.issue  = issue_c;
    hz.fwd_a  = (issue_c && hit_a) ? sel_a : '0;
    hz.fwd_b  = (issue_c && hit_b) ? sel_b : '0;
  end

  always_comb begin
    id_entry       = '0;
    id_entry.v     = 1'b1;
    id_entry.rd    = hz.id_rd;
    id_entry.regwr = hz.id_regwr;
    id_entry.memrd = hz.id_memrd;
  end

  assign hz.stall_cnt = stall_cnt_q;

  // Tracking shift register and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(FWD_STAGES); k++) begin
        trk_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      trk_q[0] <= issue_c ? id_entry : '0;
      for (int k = 1; k < int'(FWD_STAGES); k++) begin
        trk_q[k] <= trk_q[k-1];
      end
      if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
